// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one single-port data memory
// between the main core (port A) and the io/monitor core (port B). Read data
// is tagged back to the issuing port. A saturating counter records cycles
// in which both ports competed.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          a_block,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflicts,
  input  logic          clr_conflicts
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          ra;
  logic          rb;
  logic          grant_a;
  logic          grant_b;
  logic          last_reg;      // port granted most recently: 0 = A, 1 = B
  logic          rd_a_reg;
  logic          rd_b_reg;
  logic [CW-1:0] conflicts_reg;

  // Effective requests and round-robin grant; reset forces every grant low
  // so the memory is never strobed while reset_n is asserted.
  always_comb begin
    ra      = a_req & ~a_block;
    rb      = b_req;
    grant_a = reset_n & ra & (~rb | last_reg);
    grant_b = reset_n & rb & (~ra | ~last_reg);
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  // Memory request mux: the granted port drives the memory, idle drives zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (grant_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Round-robin state: remember which port was granted last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_reg <= 1'b1;
    end else if (grant_a) begin
      last_reg <= 1'b0;
    end else if (grant_b) begin
      last_reg <= 1'b1;
    end
  end

  // Read tag pipe: marks which port owns the memory data next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_reg <= 1'b0;
      rd_b_reg <= 1'b0;
    end else begin
      rd_a_reg <= grant_a & ~a_we;
      rd_b_reg <= grant_b & ~b_we;
    end
  end

  assign a_rvalid = rd_a_reg;
  assign b_rvalid = rd_b_reg;
  assign a_rdata  = rd_a_reg ? mem_rdata : '0;
  assign b_rdata  = rd_b_reg ? mem_rdata : '0;

  // Saturating conflict counter; a clear wins over a same-cycle conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflicts_reg <= '0;
    end else if (clr_conflicts) begin
      conflicts_reg <= '0;
    end else if (ra && rb && (conflicts_reg != CNT_MAX)) begin
      conflicts_reg <= conflicts_reg + CNT_ONE;
    end
  end

  assign conflicts = conflicts_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters.
  - Port A is the main discus core.
  - Port B is the io/monitor discus core.
- Replaces the present dual-writer arrangement with one clocked access point.
- Grants at most one access per cycle, using round-robin priority.
- Tags read data back to the requester that issued the read.
- Keeps a saturating conflict counter that the monitor reads for bring-up.

Parameters:
- AW, 8, memory address width.
- DW, 8, data width.
- CW, 16, width of the conflict counter.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request, level-held until granted.
- a_we  in  1  port A write (1) or read (0).
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_gnt  out  1  port A access issued this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DW  port A read data; 0 when a_rvalid=0.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for port B.
- a_block  in  1  when 1, a_req is ignored (core A held in reset by the monitor).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0.
- conflicts  out  CW  count of cycles where both effective requests were present.
- clr_conflicts  in  1  synchronous clear of conflicts.

Behaviour:
- Effective requests:
  - ra = a_req & !a_block.
  - rb = b_req.
- Grant logic (combinational from ra, rb and the registered state `last`):
  - Only ra: A granted.
  - Only rb: B granted.
  - Both: grant the port that was not granted last.
  - Neither: no grant.
  - a_gnt and b_gnt are never both 1.
- Memory drive:
  - mem_en equals (a_gnt | b_gnt).
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - With no grant, all four outputs are 0.
- `last` register:
  - Updates only on a grant, to the granted port (A=0, B=1).
  - Reset value is 1, so A wins the first conflict after reset.
- Read return:
  - Registered tag pipe: rd_a <= a_gnt & !a_we; rd_b <= b_gnt & !b_we.
  - a_rvalid = rd_a and b_rvalid = rd_b.
  - x_rdata = mem_rdata when x_rvalid=1, else 0.
  - Read latency: 1 cycle after gnt.
  - Back-to-back reads from alternating ports are supported, one per cycle.
- Requester handshake:
  - The requester holds req, we, addr and wdata stable until it sees gnt=1 in the same cycle.
  - On the following cycle the requester may present a new request or drop req.
  - An ungranted requester waits; with round-robin the wait is at most 1 cycle.
- a_block:
  - Takes effect combinationally.
  - An A read already granted still returns a_rvalid on the next cycle.
- Conflict counter:
  - Increments when ra & rb.
  - Saturates at all-ones.
  - clr_conflicts has priority over the increment.
- Reset values (reset_n=0):
  - last=1.
  - rd_a=rd_b=0.
  - conflicts=0.
  - All gnt, rvalid, rdata and mem_* outputs are 0 while reset_n=0, regardless of requests.
- Reset mid-read: the pending rvalid is discarded and is not reissued after reset release.
- Same-address write A then read B on consecutive cycles: B returns the new data. The write completes in the memory before the following read is issued.
- Widths: no arithmetic on the datapath. The counter is CW bits with explicit saturation, no wrap.

Test Plan:
- Single reads:
  - Stimulus: after reset, B writes 0x5A to 0x10, then A reads 0x10.
  - Required: b_gnt in cycle 0; a_gnt in cycle 1; a_rvalid=1 with a_rdata=0x5A in cycle 2; b_rvalid stays 0.
- Conflict alternation:
  - Stimulus: ra and rb held for 4 cycles.
  - Required: grant order A,B,A,B; conflicts=4; rvalid follows each read grant by 1 cycle with correct port tagging.
- a_block:
  - Stimulus: a_block=1 with a_req=1 and b_req=1.
  - Required: only b_gnt is asserted; conflicts does not increment; an A read granted the cycle before still returns a_rvalid.
- Saturation:
  - Stimulus: CW=4, 20 conflict cycles.
  - Required: conflicts=0xF, then clr_conflicts gives 0 on the next cycle even with a simultaneous conflict.
- Reset mid-read:
  - Stimulus: A read granted, then reset_n=0 in the next cycle.
  - Required: a_rvalid=0 and mem_en=0 immediately (asynchronous); after release `last`=1 and the first conflict grants A.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: mem_en=0, mem_addr=0, all rdata=0.
